// File: rtl/frequency_divider.sv
// frequency_divider: measures the period of InFreq in ref_f cycles and
// regenerates it on outFreq with the period multiplied by 2^n.
module frequency_divider #(
  parameter int PW   = 16,
  parameter int NMAX = 8
) (
  input  logic       ref_f,
  input  logic       rst,
  input  logic       InFreq,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] n,
  output logic       outFreq,
  output logic       busy,
  output logic       locked,
  output logic       overflow
);

  localparam int TW = PW + NMAX;
  localparam logic [3:0] NQMAX = 4'(NMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_LOAD,
    S_RUN
  } state_t;

  state_t          r_state;
  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic [PW-1:0]   r_cnt;
  logic [PW-1:0]   r_p;
  logic [3:0]      r_nq;
  logic [TW-1:0]   r_ph;
  logic            r_out;
  logic            r_busy;
  logic            r_locked;
  logic            r_ovf;

  logic            w_rise;
  logic            w_cnt_max;
  logic [3:0]      w_nq;
  logic [TW-1:0]   w_t;
  logic [TW-1:0]   w_hi;
  logic [TW-1:0]   w_lo;

  always_ff @(posedge ref_f) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= InFreq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_cnt_max = (r_cnt == '1);
  assign w_nq      = (n > NQMAX) ? NQMAX : n;

  // Full-width shift; odd T puts the extra cycle in the low phase.
  assign w_t  = TW'(r_p) << r_nq;
  assign w_hi = w_t >> 1;
  assign w_lo = w_t - w_hi;

  always_ff @(posedge ref_f) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_nq     <= '0;
      r_ph     <= '0;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (stop) begin
      r_state  <= S_IDLE;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_locked <= 1'b0;
    end else if (start) begin
      r_state  <= S_ARM;
      r_nq     <= w_nq;
      r_ovf    <= 1'b0;
      r_out    <= 1'b0;
      r_busy   <= 1'b1;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out    <= 1'b0;
          r_busy   <= 1'b0;
          r_locked <= 1'b0;
        end
        S_ARM: begin
          if (w_rise) begin
            r_cnt   <= PW'(1);
            r_state <= S_MEAS;
          end
        end
        S_MEAS: begin
          if (w_rise) begin
            r_p     <= r_cnt;
            r_state <= S_LOAD;
          end else if (w_cnt_max) begin
            r_ovf   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
        S_LOAD: begin
          r_ph     <= w_hi;
          r_out    <= 1'b1;
          r_busy   <= 1'b0;
          r_locked <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          // Reload on the toggling edge so phases abut with no gap.
          if (r_ph == TW'(1)) begin
            r_out <= ~r_out;
            r_ph  <= r_out ? w_lo : w_hi;
          end else begin
            r_ph <= r_ph - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign outFreq  = r_out;
  assign busy     = r_busy;
  assign locked   = r_locked;
  assign overflow = r_ovf;

endmodule
